// File: rtl/mem_definitions.sv
// Shared memory-access types for the fetch/data memory port arbiter.
// Mask encodings, arbiter FSM states and transaction ownership.
package mem_definitions;

  typedef enum logic [2:0] {
    MEM_BYTE  = 3'd0,
    MEM_HALF  = 3'd1,
    MEM_WORD  = 3'd2,
    MEM_BYTEU = 3'd4,
    MEM_HALFU = 3'd5
  } mem_mask_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  function automatic logic is_busy(arb_state_t s);
    return (s == IF_BUSY) || (s == DM_BUSY);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// BUSY-cycle watchdog for the memory port arbiter.
// Built only when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_busy,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  assign o_expired = i_busy &&
    (r_cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_busy && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-ported req/ack memory.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_definitions::*;
#(
  parameter int DATA_STREAK    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  mem_mask_t   dm_mask,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output mem_mask_t   mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_err
);

  localparam int SW = $clog2(DATA_STREAK + 1);

  arb_state_t  r_state;
  arb_state_t  w_next;
  arb_owner_t  r_owner;
  logic [SW-1:0] r_streak;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  mem_mask_t   r_mask;
  logic        r_we;

  logic w_dm_req;
  logic w_dm_win;
  logic w_dm_grant;
  logic w_if_grant;
  logic w_grant;
  logic w_busy;
  logic w_expire;

  assign w_dm_req = dm_read | dm_write;
  // Streak only throttles data while fetch is actually waiting.
  assign w_dm_win = w_dm_req &&
    ((r_streak < SW'(DATA_STREAK)) || !if_req);
  assign w_dm_grant = (r_state == IDLE) && w_dm_win;
  assign w_if_grant = (r_state == IDLE) && !w_dm_win && if_req;
  assign w_grant    = w_dm_grant | w_if_grant;
  assign w_busy     = is_busy(r_state);

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_err;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_grant),
    .i_busy   (w_busy),
    .o_expired(w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_grant) begin
      r_err <= 1'b0;
    end else if (w_busy && !mem_ack && w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = (r_state == RESP) && r_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_expire    = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dm_grant) begin
          w_next = DM_BUSY;
        end else if (w_if_grant) begin
          w_next = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack || w_expire) begin
          w_next = RESP;
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    if_valid = 1'b0;
    dm_done  = 1'b0;
    unique case (r_state)
      IF_BUSY, DM_BUSY: mem_req = 1'b1;
      RESP: begin
        if_valid = (r_owner == OWN_IF);
        dm_done  = (r_owner == OWN_DM);
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (!if_req || w_if_grant) begin
      r_streak <= '0;
    end else if (w_dm_grant &&
                 (r_streak < SW'(DATA_STREAK))) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // A store wins over a load if both levels are up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mask  <= MEM_WORD;
      r_we    <= 1'b0;
      r_owner <= OWN_IF;
    end else if (w_dm_grant) begin
      r_addr  <= dm_addr;
      r_wdata <= dm_wdata;
      r_mask  <= dm_mask;
      r_we    <= dm_write;
      r_owner <= OWN_DM;
    end else if (w_if_grant) begin
      r_addr  <= if_addr;
      r_wdata <= '0;
      r_mask  <= MEM_WORD;
      r_we    <= 1'b0;
      r_owner <= OWN_IF;
    end else if (w_busy && mem_ack) begin
      r_rdata <= mem_rdata;
    end else if (w_busy && w_expire) begin
      r_rdata <= '0;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask  = r_mask;
  assign if_rdata  = r_rdata;
  assign dm_rdata  = r_rdata;
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = w_dm_req & ~dm_done;

  a_rw_both: assert property (
    @(posedge clk) disable iff (rst)
    !(dm_read && dm_write)
  ) else $error("dm_read and dm_write both high");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Timeout steps run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
  import mem_definitions::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  mem_mask_t   dm_mask;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_mask_t   mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] grants [32];
  int n;

  mem_port_arbiter #(
    .DATA_STREAK   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_mask  (dm_mask),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_mask (mem_mask),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_err  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    dm_read = 0; dm_write = 0;
    dm_addr = 0; dm_wdata = 0; dm_mask = MEM_WORD;
    mem_rdata = 0; mem_ack = 0;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mask", mem_mask, MEM_WORD);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", dm_rdata, 0);
    rst = 1'b0;

    // fetch only, ack one cycle after mem_req
    cyc();
    if_req = 1; if_addr = 32'h100; #1;
    chk("f_stall", if_stall, 1);
    chk("f_req0", mem_req, 0);
    cyc(); #1;
    chk("f_req1", mem_req, 1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_mask", mem_mask, MEM_WORD);
    chk("f_we", mem_we, 0);
    cyc();
    mem_ack = 1; mem_rdata = 32'h1111_2222; #1;
    chk("f_req2", mem_req, 1);
    chk("f_valid_early", if_valid, 0);
    cyc();
    mem_ack = 0; #1;
    chk("f_valid", if_valid, 1);
    chk("f_rdata", if_rdata, 32'h1111_2222);
    chk("f_stall_done", if_stall, 0);
    chk("f_req_drop", mem_req, 0);
    if_req = 0;
    cyc(); #1;
    chk("f_valid_pulse", if_valid, 0);

    // simultaneous: data first, then fetch
    cyc();
    if_req = 1; if_addr = 32'h300;
    dm_write = 1; dm_addr = 32'h200;
    dm_wdata = 32'hCAFE_F00D; dm_mask = MEM_BYTE; #1;
    chk("s_dm_stall", dm_stall, 1);
    cyc();
    mem_ack = 1; mem_rdata = 0; #1;
    chk("s_we", mem_we, 1);
    chk("s_addr", mem_addr, 32'h200);
    chk("s_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("s_mask", mem_mask, MEM_BYTE);
    cyc();
    mem_ack = 0; #1;
    chk("s_dm_done", dm_done, 1);
    chk("s_dm_stall0", dm_stall, 0);
    chk("s_if_stall", if_stall, 1);
    dm_write = 0;
    cyc(); #1;
    chk("s_idle_req", mem_req, 0);
    cyc();
    mem_ack = 1; mem_rdata = 32'hABCD_0001; #1;
    chk("s_f_addr", mem_addr, 32'h300);
    chk("s_f_we", mem_we, 0);
    chk("s_f_mask", mem_mask, MEM_WORD);
    cyc();
    mem_ack = 0; #1;
    chk("s_f_valid", if_valid, 1);
    chk("s_f_rdata", if_rdata, 32'hABCD_0001);
    if_req = 0;
    cyc();

    // streak: 4 loads, 1 fetch, repeat
    if_req = 1; if_addr = 32'h400;
    dm_read = 1; dm_addr = 32'h500; dm_mask = MEM_WORD;
    mem_ack = 1; mem_rdata = 32'h55; #1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && n < 32) begin
        grants[n] = mem_addr;
        n++;
      end
      cyc(); #1;
    end
    if_req = 0; dm_read = 0; mem_ack = 0;
    chk("k_count", n, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("k_grant%0d", k), grants[k],
          (k == 4 || k == 9) ? 32'h400 : 32'h500);
    end

    // ack delayed 10 cycles
    cyc();
    dm_read = 1; dm_addr = 32'h600; dm_mask = MEM_HALF;
    if_req = 1; if_addr = 32'h700; #1;
    cyc(); #1;
    for (int i = 0; i < 10; i++) begin
      chk("d_req", mem_req, 1);
      chk("d_addr", mem_addr, 32'h600);
      chk("d_mask", mem_mask, MEM_HALF);
      chk("d_dm_stall", dm_stall, 1);
      chk("d_if_stall", if_stall, 1);
      cyc(); #1;
    end
    mem_ack = 1; mem_rdata = 32'h5A5A_5A5A; #1;
    cyc(); #1;
    chk("d_done", dm_done, 1);
    chk("d_rdata", dm_rdata, 32'h5A5A_5A5A);
    chk("d_dm_stall0", dm_stall, 0);
    chk("d_if_stall1", if_stall, 1);
    dm_read = 0;
    cyc(); #1;
    chk("d_ack_idle_req", mem_req, 0);
    chk("d_ack_idle_valid", if_valid, 0);
    mem_ack = 0;
    cyc(); #1;
    chk("d_f_req", mem_req, 1);
    chk("d_f_addr", mem_addr, 32'h700);
    cyc();
    if_req = 0; mem_ack = 1; mem_rdata = 32'h77; #1;
    chk("d_f_valid0", if_valid, 0);
    cyc();
    mem_ack = 0; #1;
    chk("d_f_valid", if_valid, 1);
    chk("d_f_rdata", if_rdata, 32'h77);
    chk("d_f_stall", if_stall, 0);

    // reset in DM_BUSY
    cyc();
    dm_write = 1; dm_addr = 32'h800;
    dm_wdata = 32'h1234; dm_mask = MEM_WORD; #1;
    cyc(); #1;
    chk("r_busy", mem_req, 1);
    rst = 1; dm_write = 0; #1;
    chk("r_req0", mem_req, 0);
    chk("r_addr0", mem_addr, 0);
    chk("r_we0", mem_we, 0);
    chk("r_done0", dm_done, 0);
    cyc(); #1;
    chk("r_done1", dm_done, 0);
    rst = 0;
    cyc(); #1;
    chk("r_done2", dm_done, 0);
    chk("r_req2", mem_req, 0);
    dm_read = 1; dm_addr = 32'h900; #1;
    cyc(); #1;
    chk("r_n_req", mem_req, 1);
    chk("r_n_addr", mem_addr, 32'h900);
    chk("r_n_we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'h9999; #1;
    cyc();
    mem_ack = 0; #1;
    chk("r_n_done", dm_done, 1);
    chk("r_n_rdata", dm_rdata, 32'h9999);
    dm_read = 0;
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    dm_read = 1; dm_addr = 32'hA00; #1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk("t_req", mem_req, 1);
      chk("t_done0", dm_done, 0);
    end
    cyc(); #1;
    chk("t_done", dm_done, 1);
    chk("t_err", mem_err, 1);
    chk("t_rdata", dm_rdata, 0);
    chk("t_req_drop", mem_req, 0);
    dm_read = 0;
    cyc(); #1;
    chk("t_err_pulse", mem_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
